// File: rtl/riscv_trace_monitor.sv
// Trace monitor for a RISC-V core: captures retired PCs into a circular
// buffer while running, stops on a self-loop (the same PC retired
// repeatedly) or on a cycle budget, then lets the buffer be read out
// oldest-first.
module riscv_trace_monitor #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 16,
   parameter int HALT_REPEAT = 4,
   parameter int MAX_CYCLES  = 50
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic                     pc_valid_i,
   input  logic                     rd_en_i,
   output logic [XLEN-1:0]          rd_data_o,
   output logic                     rd_valid_o,
   output logic                     run_o,
   output logic                     done_o,
   output logic [1:0]               halt_cause_o,
   output logic [31:0]              cycle_cnt_o,
   output logic [$clog2(DEPTH):0]   entries_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = $clog2(HALT_REPEAT + 1);

   localparam logic [AW:0]   FULL        = (AW + 1)'(DEPTH);
   localparam logic [RW-1:0] REP_HALT    = RW'(HALT_REPEAT);
   localparam logic [31:0]   CYCLE_LAST  = 32'(MAX_CYCLES - 1);
   localparam logic [1:0]    CAUSE_LOOP  = 2'b01;
   localparam logic [1:0]    CAUSE_TIME  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state, next_state;
   logic [XLEN-1:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [RW-1:0]     rep_cnt, rep_next;
   logic [XLEN-1:0]   last_pc;
   logic              loop_hit, time_hit;
   logic              capture, start_run, do_read;

   assign capture   = (state == S_RUN) && pc_valid_i;
   assign start_run = (state != S_RUN) && start_i;
   assign do_read   = (state == S_DONE) && !start_i && rd_en_i && (entries_o != '0);

   assign run_o  = (state == S_RUN);
   assign done_o = (state == S_DONE);

   // State register.
   // NOTE: every clocked process uses non-blocking assignments so all
   // registers sample the same pre-edge values regardless of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next state, repeat-count update and halt detection.
   // NOTE: every output of this block gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      next_state = state;
      rep_next   = rep_cnt;
      loop_hit   = 1'b0;
      time_hit   = 1'b0;
      case (state)
         S_IDLE: if (start_i) next_state = S_RUN;
         S_RUN: begin
            if (pc_valid_i) begin
               // rep_cnt==0 marks the first valid PC of the run.
               rep_next = (rep_cnt != '0 && pc_i == last_pc) ? rep_cnt + 1'b1 : RW'(1);
               loop_hit = (rep_next == REP_HALT);
            end
            time_hit = (cycle_cnt_o == CYCLE_LAST);
            if (loop_hit || time_hit) next_state = S_DONE;
         end
         S_DONE: if (start_i) next_state = S_RUN;
         default: next_state = S_IDLE;
      endcase
   end

   // Trace storage write port.
   // NOTE: the buffer array has no reset; entries are only ever read after
   // being written in the current run, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (capture) mem[wr_ptr] <= pc_i;
   end

   // Pointers, counters, status and readout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         entries_o    <= '0;
         cycle_cnt_o  <= '0;
         overflow_o   <= 1'b0;
         halt_cause_o <= 2'b00;
         rep_cnt      <= '0;
         last_pc      <= '0;
         rd_data_o    <= '0;
         rd_valid_o   <= 1'b0;
      end else begin
         rd_valid_o <= 1'b0;
         if (start_run) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            entries_o    <= '0;
            cycle_cnt_o  <= '0;
            overflow_o   <= 1'b0;
            halt_cause_o <= 2'b00;
            rep_cnt      <= '0;
         end else if (state == S_RUN) begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (pc_valid_i) begin
               wr_ptr  <= wr_ptr + 1'b1;
               last_pc <= pc_i;
               rep_cnt <= rep_next;
               if (entries_o == FULL) begin
                  // Full: the write lands on the oldest entry, so drop it.
                  rd_ptr     <= rd_ptr + 1'b1;
                  overflow_o <= 1'b1;
               end else begin
                  entries_o <= entries_o + 1'b1;
               end
            end
            // Self-loop wins when both limits are hit on the same edge.
            if (loop_hit)      halt_cause_o <= CAUSE_LOOP;
            else if (time_hit) halt_cause_o <= CAUSE_TIME;
         end else if (do_read) begin
            rd_data_o  <= mem[rd_ptr];
            rd_valid_o <= 1'b1;
            rd_ptr     <= rd_ptr + 1'b1;
            entries_o  <= entries_o - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_riscv_trace_monitor.sv
// Directed bench for riscv_trace_monitor with DEPTH=4, HALT_REPEAT=3,
// MAX_CYCLES=10: a vector table for the two main runs plus hand-written
// sequences for gaps, coincident halts and asynchronous reset.
module tb_riscv_trace_monitor;

   localparam int XLEN = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start_i;
   logic [XLEN-1:0]  pc_i;
   logic             pc_valid_i;
   logic             rd_en_i;
   logic [XLEN-1:0]  rd_data_o;
   logic             rd_valid_o;
   logic             run_o;
   logic             done_o;
   logic [1:0]       halt_cause_o;
   logic [31:0]      cycle_cnt_o;
   logic [2:0]       entries_o;
   logic             overflow_o;

   int tests = 0;
   int fails = 0;

   riscv_trace_monitor #(
      .XLEN(XLEN), .DEPTH(DEPTH), .HALT_REPEAT(3), .MAX_CYCLES(10)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .pc_i(pc_i),
      .pc_valid_i(pc_valid_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
      .rd_valid_o(rd_valid_o), .run_o(run_o), .done_o(done_o),
      .halt_cause_o(halt_cause_o), .cycle_cnt_o(cycle_cnt_o),
      .entries_o(entries_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        valid;
      logic [31:0] pc;
      logic        rd;
      logic [31:0] run;
      logic [31:0] done;
      logic [31:0] cause;
      logic [31:0] entries;
      logic [31:0] cycle;
      logic [31:0] ovf;
      logic [31:0] rdv;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic v, input logic [31:0] p, input logic r);
      start_i = s; pc_valid_i = v; pc_i = p; rd_en_i = r;
   endtask

   function automatic void add(input logic s, input logic v, input logic [31:0] p, input logic r,
                               input int run, input int done, input int cause, input int ent,
                               input int cyc, input int ovf, input int rdv, input logic [31:0] rdata);
      vecs.push_back('{s, v, p, r, 32'(run), 32'(done), 32'(cause), 32'(ent),
                       32'(cyc), 32'(ovf), 32'(rdv), rdata});
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      drive(0, 0, 0, 0);
      reset = 1'b1;
      tick(); tick();
      #2 reset = 1'b0;
      tick();

      // Reset state.
      check("reset_run", 32'(run_o), 0);
      check("reset_done", 32'(done_o), 0);
      check("reset_entries", 32'(entries_o), 0);
      check("reset_cycle", cycle_cnt_o, 0);
      check("reset_rd_data", rd_data_o, 0);

      // Self-loop run: 0x00,0x04,0x08,0x08,0x08 then four reads.
      //  s  v  pc    rd run done cause ent cyc ovf rdv rdata
      add(1, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 'h00, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      add(0, 1, 'h04, 0, 1, 0, 0, 2, 2, 0, 0, 0);
      add(0, 1, 'h08, 0, 1, 0, 0, 3, 3, 0, 0, 0);
      add(0, 1, 'h08, 0, 1, 0, 0, 4, 4, 0, 0, 0);
      add(0, 1, 'h08, 0, 0, 1, 1, 4, 5, 1, 0, 0);
      add(0, 1, 'h99, 1, 0, 1, 1, 3, 5, 1, 1, 'h04);
      add(0, 0, 0,    1, 0, 1, 1, 2, 5, 1, 1, 'h08);
      add(0, 0, 0,    1, 0, 1, 1, 1, 5, 1, 1, 'h08);
      add(0, 0, 0,    0, 0, 1, 1, 1, 5, 1, 0, 'h08);
      add(0, 0, 0,    1, 0, 1, 1, 0, 5, 1, 1, 'h08);
      add(0, 0, 0,    1, 0, 1, 1, 0, 5, 1, 0, 'h08);
      // Restart from DONE clears everything.
      add(1, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 'h08);
      // Timeout run: incrementing PCs every cycle; start/rd mid-run ignored.
      for (int k = 0; k < 10; k++)
         add(k == 2, 1, 32'(4 * k), k == 2, k != 9, k == 9, (k == 9) ? 2 : 0,
             (k < 4) ? k + 1 : 4, k + 1, k >= 4, 0, 'h08);
      add(0, 0, 0,    1, 0, 1, 2, 3, 10, 1, 1, 'h18);
      add(0, 0, 0,    1, 0, 1, 2, 2, 10, 1, 1, 'h1C);
      add(0, 0, 0,    1, 0, 1, 2, 1, 10, 1, 1, 'h20);
      add(0, 0, 0,    1, 0, 1, 2, 0, 10, 1, 1, 'h24);
      add(0, 0, 0,    1, 0, 1, 2, 0, 10, 1, 0, 'h24);

      foreach (vecs[i]) begin
         drive(vecs[i].start, vecs[i].valid, vecs[i].pc, vecs[i].rd);
         tick();
         check($sformatf("v%0d_run", i), 32'(run_o), vecs[i].run);
         check($sformatf("v%0d_done", i), 32'(done_o), vecs[i].done);
         check($sformatf("v%0d_cause", i), 32'(halt_cause_o), vecs[i].cause);
         check($sformatf("v%0d_entries", i), 32'(entries_o), vecs[i].entries);
         check($sformatf("v%0d_cycle", i), cycle_cnt_o, vecs[i].cycle);
         check($sformatf("v%0d_overflow", i), 32'(overflow_o), vecs[i].ovf);
         check($sformatf("v%0d_rd_valid", i), 32'(rd_valid_o), vecs[i].rdv);
         check($sformatf("v%0d_rd_data", i), rd_data_o, vecs[i].rdata);
      end

      // 0x10,0x14,0x10 resets the repeat count: no self-loop, timeout instead.
      drive(1, 0, 0, 0);     tick();
      drive(0, 1, 'h10, 0);  tick();
      drive(0, 1, 'h14, 0);  tick();
      drive(0, 1, 'h10, 0);  tick();
      check("norepeat_run", 32'(run_o), 1);
      check("norepeat_cause", 32'(halt_cause_o), 0);
      drive(0, 0, 0, 0);
      n = 0;
      while (!done_o && n < 20) begin
         tick();
         n++;
      end
      check("norepeat_timeout_done", 32'(done_o), 1);
      check("norepeat_timeout_cause", 32'(halt_cause_o), 2);
      check("norepeat_timeout_cycle", cycle_cnt_o, 10);

      // Gaps between identical valid PCs do not break the repeat.
      drive(1, 0, 0, 0);     tick();
      drive(0, 1, 'h10, 0);  tick();
      drive(0, 0, 'h10, 0);  tick();
      drive(0, 1, 'h10, 0);  tick();
      drive(0, 0, 'h10, 0);  tick();
      check("gap_not_yet_done", 32'(done_o), 0);
      drive(0, 1, 'h10, 0);  tick();
      check("gap_done", 32'(done_o), 1);
      check("gap_cause", 32'(halt_cause_o), 1);
      check("gap_cycle", cycle_cnt_o, 5);
      check("gap_entries", 32'(entries_o), 3);

      // Repeat limit and cycle budget reached on the same edge.
      drive(1, 0, 0, 0);     tick();
      drive(0, 0, 0, 0);
      for (int k = 0; k < 7; k++) tick();
      drive(0, 1, 'h40, 0);
      tick(); tick(); tick();
      check("both_done", 32'(done_o), 1);
      check("both_cause", 32'(halt_cause_o), 1);
      check("both_cycle", cycle_cnt_o, 10);
      check("both_entries", 32'(entries_o), 3);
      drive(0, 0, 0, 1);     tick();
      check("both_read_valid", 32'(rd_valid_o), 1);
      check("both_read_data", rd_data_o, 'h40);

      // Asynchronous reset mid-run, between clock edges.
      drive(1, 0, 0, 0);     tick();
      drive(0, 1, 'h100, 0); tick();
      drive(0, 1, 'h104, 0); tick();
      check("prereset_entries", 32'(entries_o), 2);
      #2 reset = 1'b1;
      #1;
      check("areset_run", 32'(run_o), 0);
      check("areset_done", 32'(done_o), 0);
      check("areset_cause", 32'(halt_cause_o), 0);
      check("areset_entries", 32'(entries_o), 0);
      check("areset_cycle", cycle_cnt_o, 0);
      check("areset_overflow", 32'(overflow_o), 0);
      check("areset_rd_valid", 32'(rd_valid_o), 0);
      check("areset_rd_data", rd_data_o, 0);
      #3 reset = 1'b0;
      tick(); tick();
      check("postreset_idle_run", 32'(run_o), 0);
      check("postreset_idle_cycle", cycle_cnt_o, 0);
      check("postreset_idle_entries", 32'(entries_o), 0);
      drive(0, 0, 0, 1);     tick();
      check("idle_read_valid", 32'(rd_valid_o), 0);
      drive(1, 0, 0, 0);     tick();
      check("restart_run", 32'(run_o), 1);
      drive(0, 0, 0, 0);     tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/riscv_trace_monitor.md
RISCV_TRACE_MONITOR -- requirements
Module: riscv_trace_monitor

Interface
REQ-001 Parameter XLEN, 32, width of the captured program counter.
REQ-002 Parameter DEPTH, 16, trace buffer entries; power of two, >=2.
REQ-003 Parameter HALT_REPEAT, 4, consecutive identical valid PCs that declare a self-loop halt; >=2.
REQ-004 Parameter MAX_CYCLES, 50, RUN-state cycle budget before timeout halt; >=1.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start_i  input  1  single-cycle pulse; begins a capture run.
REQ-008 Port pc_i  input  XLEN  processor PC for the current cycle.
REQ-009 Port pc_valid_i  input  1  pc_i is a retired PC to capture.
REQ-010 Port rd_en_i  input  1  pop the oldest buffered entry.
REQ-011 Port rd_data_o  output  XLEN  popped entry, registered.
REQ-012 Port rd_valid_o  output  1  rd_data_o valid, one-cycle pulse.
REQ-013 Port run_o  output  1  state is RUN.
REQ-014 Port done_o  output  1  state is DONE.
REQ-015 Port halt_cause_o  output  2  00 none, 01 self-loop, 10 timeout.
REQ-016 Port cycle_cnt_o  output  32  RUN cycles elapsed in the current run.
REQ-017 Port entries_o  output  clog2(DEPTH)+1  valid entries in the buffer.
REQ-018 Port overflow_o  output  1  sticky; at least one entry was overwritten in the current run.

Function
REQ-019 The block SHALL implement states IDLE, RUN, and DONE: IDLE->RUN on start_i; RUN->DONE on halt; DONE->RUN on start_i; start_i in RUN SHALL be ignored.
REQ-020 Entry to RUN SHALL clear the buffer pointers, entries_o, cycle_cnt_o, overflow_o, halt_cause_o, and the repeat counter in the same edge.
REQ-021 In RUN, cycle_cnt_o SHALL increment by 1 per clock, counting the cycle it is evaluated in.
REQ-022 In RUN with pc_valid_i=1, pc_i SHALL be written at wr_ptr; wr_ptr SHALL wrap from DEPTH-1 to 0.
REQ-023 Buffer not full: entries_o SHALL increment. Buffer full: the oldest entry SHALL be overwritten, rd_ptr SHALL advance, entries_o SHALL stay at DEPTH, and overflow_o SHALL set.
REQ-024 Repeat counter: the first valid PC of a run sets it to 1; each later valid PC equal to the last valid PC increments it; an unequal PC sets it to 1; invalid cycles leave it unchanged.
REQ-025 When the repeat counter reaches HALT_REPEAT, the block SHALL move to DONE at that edge with halt_cause_o=01; the triggering PC SHALL still be captured.
REQ-026 When cycle_cnt_o reaches MAX_CYCLES, the block SHALL move to DONE with halt_cause_o=10.
REQ-027 If both halt conditions occur on the same edge, halt_cause_o SHALL be 01.
REQ-028 In IDLE and DONE, pc_valid_i SHALL be ignored and cycle_cnt_o SHALL hold.
REQ-029 In DONE with rd_en_i=1 and entries_o>0, the next edge SHALL: load rd_data_o with the oldest entry, pulse rd_valid_o high for one cycle, advance rd_ptr (wrapping), and decrement entries_o.
REQ-030 A rd_en_i in any state other than DONE, or with entries_o=0, SHALL leave rd_valid_o=0 and change no state.
REQ-031 Back-to-back rd_en_i SHALL return entries oldest-first, at one entry per cycle.
REQ-032 rd_data_o SHALL hold its last value when no read occurs.

Reset
REQ-033 reset=1 SHALL force, asynchronously: state IDLE, all pointers and counters 0, rd_data_o=0, rd_valid_o=0, run_o=0, done_o=0, halt_cause_o=00, overflow_o=0, entries_o=0, cycle_cnt_o=0.
REQ-034 Reset asserted during RUN or readout SHALL discard the run; after release the block SHALL wait in IDLE for start_i.
REQ-035 Buffer storage contents need no reset; they SHALL be unobservable until rewritten.

Verification (DEPTH=4, HALT_REPEAT=3, MAX_CYCLES=10, XLEN=32)
REQ-036 start_i; valid PCs 0x00,0x04,0x08,0x08,0x08 -> DONE after the 5th with cause 01; entries_o=4, overflow_o=1; four reads return 0x04,0x08,0x08,0x08.
REQ-037 start_i; valid PCs 0x00,0x04,... incrementing every cycle -> DONE with cause 10 and cycle_cnt_o=10; reads return 0x18,0x1C,0x20,0x24; a 5th read gives rd_valid_o=0.
REQ-038 PCs 0x10 valid, gap, 0x10 valid, gap, 0x10 valid -> self-loop halt, because gaps do not break the repeat; a reading of 0x10,0x14,0x10 resets the repeat count and gives no halt.
REQ-039 Repeat count and cycle_cnt_o reach their limits on the same edge -> halt_cause_o=01.
REQ-040 rd_en_i and start_i during RUN -> no rd_valid_o, no restart; start_i in DONE -> entries_o=0, cycle_cnt_o=0, run_o=1.
REQ-041 reset pulse mid-RUN, away from clock edges -> all outputs 0 immediately; after release run_o=0 until start_i.
